// File: rtl/glyph_scroller_if.sv
// Character/ROM/matrix signal bundle for glyph_scroller.
// master = upstream + font ROM side, slave = the scroller itself.
interface glyph_scroller_if;
    logic [6:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [6:0]  rom_addr;
    logic [34:0] rom_data;
    logic [6:0]  row_sel;
    logic [4:0]  col_out;
    logic        busy;

    modport master (
        output char_in, char_valid, rom_data,
        input  char_ready, rom_addr, row_sel, col_out, busy
    );

    modport slave (
        input  char_in, char_valid, rom_data,
        output char_ready, rom_addr, row_sel, col_out, busy
    );
endinterface

// File: rtl/glyph_scroller.sv
// Latches 5x7 glyphs from the font ROM and scrolls them column by column through a
// row-multiplexed 5x7 frame. Optional macro GLYPH_GAP_EN adds one blank column per glyph.
//
// state  | meaning
// IDLE   | frame static, waiting for a held character
// SCROLL | shifting one glyph column into the frame per scroll tick
module glyph_scroller #(
    parameter int SCROLL_DIV = 1000000,
    parameter int ROW_DIV    = 1000
) (
    input logic            clk,
    input logic            rst,
    glyph_scroller_if.slave bus
);
    localparam int TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int RW = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
`ifdef GLYPH_GAP_EN
    localparam logic [2:0] LAST_COL = 3'd5;
`else
    localparam logic [2:0] LAST_COL = 3'd4;
`endif

    typedef enum logic {IDLE, SCROLL} state_t;
    state_t state, state_nxt;

    logic              hold_valid;
    logic [6:0]        hold_code;
    logic [34:0]       glyph_reg;
    logic [2:0]        col_cnt;
    logic [6:0][4:0]   frame;
    logic [6:0]        new_col;
    logic [TW-1:0]     tick_cnt;
    logic [RW-1:0]     row_div_cnt;
    logic [2:0]        row_cnt;
    logic [6:0]        row_sel_q;
    logic [4:0]        col_q;
    logic              tick, last_tick, accept, load, shift, busy_c;

    assign bus.char_ready = !hold_valid;
    assign bus.rom_addr   = hold_code;
    assign bus.row_sel    = row_sel_q;
    assign bus.col_out    = col_q;
    assign bus.busy       = busy_c;

    assign accept    = bus.char_valid && !hold_valid;
    assign tick      = (tick_cnt == TW'(SCROLL_DIV - 1));
    assign last_tick = tick && (col_cnt == LAST_COL);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hold_valid) state_nxt = SCROLL;
            SCROLL:  if (last_tick && !hold_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A held character is loaded on the same edge that shifts the last column, so glyphs abut.
    always_comb begin
        load   = 1'b0;
        shift  = 1'b0;
        busy_c = hold_valid;
        case (state)
            IDLE:    load = hold_valid;
            SCROLL: begin
                shift  = tick;
                load   = last_tick && hold_valid;
                busy_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Column col_cnt of the glyph, one bit per row; the gap column stays blank.
    always_comb begin
        new_col = '0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 5; c++)
                if (col_cnt == 3'(c)) new_col[r] = glyph_reg[34 - (5 * r + c)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_code  <= '0;
            glyph_reg  <= '0;
            col_cnt    <= '0;
            frame      <= '0;
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
                hold_code  <= bus.char_in;
            end else if (load) begin
                hold_valid <= 1'b0;
            end
            if (shift) begin
                for (int r = 0; r < 7; r++) frame[r] <= {new_col[r], frame[r][4:1]};
            end
            if (load) begin
                glyph_reg <= bus.rom_data;
                col_cnt   <= '0;
            end else if (shift) begin
                col_cnt <= col_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt    <= '0;
            row_div_cnt <= '0;
            row_cnt     <= '0;
            row_sel_q   <= 7'b0000001;
            col_q       <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (row_div_cnt == RW'(ROW_DIV - 1)) begin
                row_div_cnt <= '0;
                row_cnt     <= (row_cnt == 3'd6) ? 3'd0 : row_cnt + 3'd1;
            end else begin
                row_div_cnt <= row_div_cnt + RW'(1);
            end
            row_sel_q <= 7'(1) << row_cnt;
            col_q     <= frame[row_cnt];
        end
    end
endmodule

// File: tb/tb_glyph_scroller.sv
// Self-checking bench for glyph_scroller: column-stream model plus directed scenarios.
module tb_glyph_scroller;
    localparam int SD = 4;
    localparam int RD = 2;
`ifdef GLYPH_GAP_EN
    localparam int CPC = 6;
    localparam logic [4:0] FULL = 5'h0F;
`else
    localparam int CPC = 5;
    localparam logic [4:0] FULL = 5'h1F;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    glyph_scroller_if bus ();

    glyph_scroller #(.SCROLL_DIV(SD), .ROW_DIV(RD)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [34:0] rom(input logic [6:0] a);
        case (a)
            7'h41:   rom = 35'h400000000;
            7'h7F:   rom = 35'h7FFFFFFFF;
            default: rom = {28'h0, a};
        endcase
    endfunction

    always_comb bus.rom_data = rom(bus.rom_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the display is the last five columns of a column stream; front of queue = leftmost.
    logic [6:0]  m_cols[$];
    int          m_cyc, m_col, m_shifts;
    bit          m_scroll, m_hold_v, m_init;
    logic [6:0]  m_hold_code;
    logic [34:0] m_glyph;
    logic [6:0]  e_row_sel;
    logic [4:0]  e_col;

    function automatic logic [6:0] glyph_col(input logic [34:0] g, input int c);
        logic [6:0] w;
        for (int r = 0; r < 7; r++) w[r] = g[34 - (5 * r + c)];
        return w;
    endfunction

    task automatic m_load();
        m_glyph  = rom(m_hold_code);
        m_hold_v = 0;
        m_col    = 0;
        m_scroll = 1;
    endtask

    initial m_shifts = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_cols      = '{7'h0, 7'h0, 7'h0, 7'h0, 7'h0};
            m_cyc       = 0;
            m_col       = 0;
            m_scroll    = 0;
            m_hold_v    = 0;
            m_hold_code = 7'h0;
            m_glyph     = 35'h0;
            e_row_sel   = 7'b0000001;
            e_col       = 5'h0;
            m_init      = 1;
        end else begin
            int row;
            bit tk, acc;
            row       = (m_cyc / RD) % 7;
            e_row_sel = 7'(1) << row;
            for (int c = 0; c < 5; c++) e_col[c] = m_cols[c][row];
            tk  = (m_cyc % SD) == SD - 1;
            acc = bus.char_valid && !m_hold_v;
            if (!m_scroll) begin
                if (m_hold_v) m_load();
            end else if (tk) begin
                m_cols.push_back((m_col < 5) ? glyph_col(m_glyph, m_col) : 7'h0);
                void'(m_cols.pop_front());
                m_col++;
                m_shifts++;
                if (m_col == CPC) begin
                    if (m_hold_v) m_load();
                    else m_scroll = 0;
                end
            end
            if (acc) begin
                m_hold_v    = 1;
                m_hold_code = bus.char_in;
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("row_sel", 35'(bus.row_sel), 35'(e_row_sel));
            chk("col_out", 35'(bus.col_out), 35'(e_col));
            chk("char_ready", 35'(bus.char_ready), 35'(!m_hold_v));
            chk("busy", 35'(bus.busy), 35'(m_scroll || m_hold_v));
            chk("rom_addr", 35'(bus.rom_addr), 35'(m_hold_code));
        end
    end

    task automatic send(input logic [6:0] code, input int budget, output int waited);
        bit done = 0;
        waited = 0;
        bus.char_in    = code;
        bus.char_valid = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            if (bus.char_ready) begin
                done   = 1;
                waited = i;
            end
            @(negedge clk);
        end
        bus.char_valid = 1'b0;
        chk("send_accepted", 35'(done), 35'd1);
    endtask

    task automatic wait_shifts(input int target, input int budget);
        int i = 0;
        while (m_shifts < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("shift_budget", 35'(m_shifts >= target), 35'd1);
    endtask

    initial begin
        int base, w, idle, i;
        logic [6:0] prev;
        bus.char_in    = 7'h0;
        bus.char_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset values and static blank frame
        chk("rst_row_sel", 35'(bus.row_sel), 35'd1);
        chk("rst_col_out", 35'(bus.col_out), 35'd0);
        chk("rst_ready", 35'(bus.char_ready), 35'd1);
        chk("rst_busy", 35'(bus.busy), 35'd0);
        repeat (20) @(negedge clk);
        for (int k = 0; k < 14; k++) begin
            chk("idle_blank", 35'(bus.col_out), 35'd0);
            @(negedge clk);
        end

        // single 0x41
        base = m_shifts;
        send(7'h41, 10, w);
        chk("t2_rom_addr", 35'(bus.rom_addr), 35'h41);
        chk("t2_busy", 35'(bus.busy), 35'd1);
        chk("t2_ready", 35'(bus.char_ready), 35'd0);
        wait_shifts(base + 5, 100);
        chk("t2_model_left", 35'(m_cols[0]), 35'h01);
        chk("t2_model_right", 35'(m_cols[4]), 35'h00);
`ifdef GLYPH_GAP_EN
        wait_shifts(base + 6, 20);
        chk("t2_gap_busy", 35'(bus.busy), 35'd0);
        @(negedge clk);
        for (int k = 0; k < 14; k++) begin
            chk("t2_gap_blank", 35'(bus.col_out), 35'd0);
            @(negedge clk);
        end
`else
        chk("t2_busy_done", 35'(bus.busy), 35'd0);
        @(negedge clk);
        i = 0;
        while (bus.row_sel != 7'b0000001 && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("t2_row0_pixel", 35'(bus.col_out), 35'b00001);
`endif

        // three back-to-back 0x41
        base = m_shifts;
        send(7'h41, 10, w);
        send(7'h41, 10, w);
        chk("t3_second_wait", 35'(w), 35'd1);
        send(7'h41, 100, w);
        chk("t3_third_after_first", 35'(m_shifts - base), 35'(CPC));
        idle = 0;
        i = 0;
        while (m_shifts < base + 3 * CPC && i < 200) begin
            if (!bus.busy) idle++;
            @(negedge clk);
            i++;
        end
        chk("t3_no_idle_gap", 35'(idle), 35'd0);
        chk("t3_done", 35'(m_shifts), 35'(base + 3 * CPC));

        // solid glyph, row scan walk
        base = m_shifts;
        send(7'h7F, 10, w);
        wait_shifts(base + CPC, 100);
        repeat (2) @(negedge clk);
        prev = bus.row_sel;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.row_sel == 7'b0000001 && prev != 7'b0000001) break;
            prev = bus.row_sel;
        end
        for (int k = 0; k < 15; k++) begin
            chk("t4_row_walk", 35'(bus.row_sel), 35'(7'(1) << ((k / 2) % 7)));
            chk("t4_full_row", 35'(bus.col_out), 35'(FULL));
            @(negedge clk);
        end

        // reset on the third tick, with a character pending
        base = m_shifts;
        send(7'h7F, 10, w);
        wait_shifts(base + 2, 40);
        send(7'h41, 10, w);
        i = 0;
        while ((m_cyc % SD) != SD - 1 && i < 10) begin
            @(negedge clk);
            i++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", 35'(bus.busy), 35'd0);
        chk("t5_ready", 35'(bus.char_ready), 35'd1);
        chk("t5_row_sel", 35'(bus.row_sel), 35'd1);
        chk("t5_col_out", 35'(bus.col_out), 35'd0);
        chk("t5_third_tick_cut", 35'(m_shifts - base), 35'd2);
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            chk("t5_blank", 35'(bus.col_out), 35'd0);
            @(negedge clk);
        end

        // held valid while hold is full
        send(7'h41, 10, w);
        send(7'h7F, 10, w);
        bus.char_valid = 1'b1;
        i = 0;
        while (!bus.char_ready && i < 100) begin
            bus.char_in = 7'(7'h15 + i);
            chk("t6_hold_kept", 35'(bus.rom_addr), 35'h7F);
            @(negedge clk);
            i++;
        end
        bus.char_in = 7'h33;
        @(negedge clk);
        bus.char_valid = 1'b0;
        chk("t6_new_accept", 35'(bus.rom_addr), 35'h33);
        repeat (60) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
